// File: rtl/job_sequencer_if.sv
// Handshake bundle between a run requester and job_sequencer.
//   master : drives go/mode/ch_en and the engine done flags, observes status
//   slave  : the sequencer itself
//   go, mode, ch_en : run request, dispatch mode (0 serial, 1 parallel), channel mask
//   ch_start        : start pulses to the engines
//   ch_done         : engine done flags (level or pulse)
//   busy, seq_done  : run in progress / one-cycle end-of-run pulse
//   timeout         : sticky abort flag
//   done_mask       : sticky per-channel completion
//   cycle_cnt       : saturating run-length counter
interface job_sequencer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
);
    logic              go;
    logic              mode;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_start;
    logic [NUM_CH-1:0] ch_done;
    logic              busy;
    logic              seq_done;
    logic              timeout;
    logic [NUM_CH-1:0] done_mask;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output go, mode, ch_en, ch_done,
        input  ch_start, busy, seq_done, timeout, done_mask, cycle_cnt
    );

    modport slave (
        input  go, mode, ch_en, ch_done,
        output ch_start, busy, seq_done, timeout, done_mask, cycle_cnt
    );
endinterface

// File: rtl/job_sequencer.sv
// Run controller issuing start pulses to NUM_CH engines and collecting their done
// flags, in serial (ascending index) or parallel dispatch, with a per-dispatch
// watchdog and a saturating run-cycle counter. All outputs are registered.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (aborts a run without seq_done)
//   ctrl_io : job_sequencer_if slave modport carrying request, engine and status signals
module job_sequencer #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned TIMEOUT = 350,
    parameter int unsigned CNT_W   = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    job_sequencer_if.slave  ctrl_io
);

    localparam int unsigned WcW = $clog2(TIMEOUT + 1);
    localparam int unsigned PcW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {StIdle, StPulse, StWait, StFinish} state_e;

    state_e            state_q;
    logic [NUM_CH-1:0] mask_q, cur_q, ch_start_q, done_mask_q;
    logic              mode_q, busy_q, seq_done_q, timeout_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [WcW-1:0]    wcnt_q;
    logic [PcW-1:0]    pcnt_q;

    logic [NUM_CH-1:0] active, dm_next, remaining, first_ch, next_ch;
    logic              chan_done, cnt_sat;
    logic [WcW-1:0]    wcnt_inc;

    function automatic logic [NUM_CH-1:0] lowest(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] res;
        logic              found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        active = '0;
        if (state_q == StPulse || state_q == StWait) begin
            // Only dispatched, still-pending channels may record a done.
            active = (mode_q ? mask_q : cur_q) & ~done_mask_q;
        end
        dm_next   = done_mask_q | (ctrl_io.ch_done & active);
        remaining = mask_q & ~dm_next;
        chan_done = mode_q ? (dm_next == mask_q) : ((cur_q & ~dm_next) == '0);
        wcnt_inc  = wcnt_q + 1'b1;
        cnt_sat   = &cycle_cnt_q;
        first_ch  = lowest(ctrl_io.ch_en);
        next_ch   = lowest(remaining);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cur_q       <= '0;
            mode_q      <= 1'b0;
            ch_start_q  <= '0;
            done_mask_q <= '0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_io.go) begin
                        mask_q      <= ctrl_io.ch_en;
                        mode_q      <= ctrl_io.mode;
                        cur_q       <= first_ch;
                        done_mask_q <= '0;
                        timeout_q   <= 1'b0;
                        cycle_cnt_q <= CNT_W'(1);
                        wcnt_q      <= '0;
                        pcnt_q      <= '0;
                        if (ctrl_io.ch_en == '0) begin
                            state_q    <= StFinish;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q    <= StPulse;
                            busy_q     <= 1'b1;
                            ch_start_q <= ctrl_io.mode ? ctrl_io.ch_en : first_ch;
                        end
                    end
                end
                StPulse, StWait: begin
                    done_mask_q <= dm_next;
                    wcnt_q      <= wcnt_inc;
                    if (!cnt_sat) begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                    // A done landing on the timeout cycle takes priority.
                    if (chan_done && (mode_q || remaining == '0)) begin
                        state_q    <= StFinish;
                        ch_start_q <= '0;
                        busy_q     <= 1'b0;
                        seq_done_q <= 1'b1;
                    end else if (chan_done) begin
                        state_q    <= StPulse;
                        cur_q      <= next_ch;
                        ch_start_q <= next_ch;
                        wcnt_q     <= '0;
                        pcnt_q     <= '0;
                    end else if (wcnt_inc == WcW'(TIMEOUT)) begin
                        state_q    <= StFinish;
                        ch_start_q <= '0;
                        busy_q     <= 1'b0;
                        seq_done_q <= 1'b1;
                        timeout_q  <= 1'b1;
                    end else if (state_q == StPulse) begin
                        if (pcnt_q == PcW'(PULSE_W - 1)) begin
                            state_q    <= StWait;
                            ch_start_q <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                    end
                end
                StFinish: begin
                    seq_done_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctrl_io.ch_start  = ch_start_q;
    assign ctrl_io.busy      = busy_q;
    assign ctrl_io.seq_done  = seq_done_q;
    assign ctrl_io.timeout   = timeout_q;
    assign ctrl_io.done_mask = done_mask_q;
    assign ctrl_io.cycle_cnt = cycle_cnt_q;

endmodule
